// File: rtl/traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// traffic_phase_controller
//
// Six-phase sequencer for a two-road intersection. The north-south main road
// rests on green; the east-west side road is served only after a latched
// request from the east-west car sensor or the pedestrian button. All phase
// durations are counted in ticks of an external one-cycle enable strobe.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   tick       : one-cycle time-base enable
//   car_ew     : east-west vehicle sensor (level)
//   ped_btn    : pedestrian crossing button (level or pulse)
//   ns_signal  : north-south light code (00 red, 01 yellow, 10 green)
//   ew_signal  : east-west light code, same encoding
//   walk       : pedestrian walk lamp, high only during east-west green
//   ew_pending : latched side-road request
// -----------------------------------------------------------------------------
module traffic_phase_controller #(
  parameter logic [7:0] NS_MIN_TICKS    = 8'd20,
  parameter logic [7:0] NS_YELLOW_TICKS = 8'd3,
  parameter logic [7:0] EW_GREEN_TICKS  = 8'd10,
  parameter logic [7:0] EW_YELLOW_TICKS = 8'd3,
  parameter logic [7:0] ALLRED_TICKS    = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       car_ew,
  input  logic       ped_btn,
  output logic [1:0] ns_signal,
  output logic [1:0] ew_signal,
  output logic       walk,
  output logic       ew_pending
);

  typedef enum logic [2:0] {
    S_NS_GREEN,
    S_NS_YELLOW,
    S_ALLRED_A,
    S_EW_GREEN,
    S_EW_YELLOW,
    S_ALLRED_B
  } state_t;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       pending_q, pending_d;
  logic [1:0] ns_q, ns_d;
  logic [1:0] ew_q, ew_d;
  logic       walk_q, walk_d;

  logic [7:0] dur;
  state_t     timed_next;

  // Duration and successor of the current timed state. NS_GREEN is not a
  // timed state; its row only supplies harmless defaults.
  always_comb begin
    dur        = ALLRED_TICKS;
    timed_next = S_NS_GREEN;
    case (state_q)
      S_NS_YELLOW: begin dur = NS_YELLOW_TICKS; timed_next = S_ALLRED_A;  end
      S_ALLRED_A:  begin dur = ALLRED_TICKS;    timed_next = S_EW_GREEN;  end
      S_EW_GREEN:  begin dur = EW_GREEN_TICKS;  timed_next = S_EW_YELLOW; end
      S_EW_YELLOW: begin dur = EW_YELLOW_TICKS; timed_next = S_ALLRED_B;  end
      S_ALLRED_B:  begin dur = ALLRED_TICKS;    timed_next = S_NS_GREEN;  end
      default:     begin dur = ALLRED_TICKS;    timed_next = S_NS_GREEN;  end
    endcase
  end

  // Next-state, timer and request latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;

    if (state_q == S_NS_GREEN) begin
      // Once the minimum green has elapsed, a pending request ends the
      // phase on the very next edge, tick or not.
      if ((timer_q == NS_MIN_TICKS) && pending_q) begin
        state_d = S_NS_YELLOW;
      end else if (tick && (timer_q != NS_MIN_TICKS)) begin
        timer_d = timer_q + 8'd1;
      end
    end else if (tick) begin
      if (timer_q == dur - 8'd1) begin
        state_d = timed_next;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end

    // A tick consumed by a transition is not counted in the new state.
    if (state_d != state_q) begin
      timer_d = 8'd0;
    end

    // Entering EW_GREEN serves the request, so a same-edge request is dropped.
    if ((state_q == S_ALLRED_A) && (state_d == S_EW_GREEN)) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q | car_ew | ped_btn;
    end
  end

  // Light decode of the next state, registered so outputs change together
  // with the state register.
  always_comb begin
    ns_d   = LIGHT_RED;
    ew_d   = LIGHT_RED;
    walk_d = 1'b0;
    case (state_d)
      S_NS_GREEN:  ns_d = LIGHT_GREEN;
      S_NS_YELLOW: ns_d = LIGHT_YELLOW;
      S_EW_GREEN:  begin ew_d = LIGHT_GREEN; walk_d = 1'b1; end
      S_EW_YELLOW: ew_d = LIGHT_YELLOW;
      default:     begin ns_d = LIGHT_RED; ew_d = LIGHT_RED; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ALLRED_B;
      timer_q   <= 8'd0;
      pending_q <= 1'b0;
      ns_q      <= LIGHT_RED;
      ew_q      <= LIGHT_RED;
      walk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      ns_q      <= ns_d;
      ew_q      <= ew_d;
      walk_q    <= walk_d;
    end
  end

  assign ns_signal  = ns_q;
  assign ew_signal  = ew_q;
  assign walk       = walk_q;
  assign ew_pending = pending_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_controller
//
// Directed bench for traffic_phase_controller with NS_MIN=4, NS_YELLOW=2,
// EW_GREEN=3, EW_YELLOW=2, ALLRED=1. Lights are compared as the 5-bit vector
// {ns_signal, ew_signal, walk}. With tick held high, NS_GREEN under a pending
// request lasts NS_MIN+1 cycles (timer 0..4, exit on the edge after it
// saturates), so a full served cycle is 5+2+1+3+2+1 = 14 cycles.
// -----------------------------------------------------------------------------
module tb_traffic_phase_controller;

  localparam logic [4:0] L_NSG = 5'b10_00_0;
  localparam logic [4:0] L_NSY = 5'b01_00_0;
  localparam logic [4:0] L_AR  = 5'b00_00_0;
  localparam logic [4:0] L_EWG = 5'b00_10_1;
  localparam logic [4:0] L_EWY = 5'b00_01_0;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       tick    = 1'b1;
  logic       car_ew  = 1'b0;
  logic       ped_btn = 1'b0;
  logic [1:0] ns_signal;
  logic [1:0] ew_signal;
  logic       walk;
  logic       ew_pending;
  logic [4:0] lights;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;
  int slow     = 0;
  int tcnt     = 0;

  traffic_phase_controller #(
    .NS_MIN_TICKS    (8'd4),
    .NS_YELLOW_TICKS (8'd2),
    .EW_GREEN_TICKS  (8'd3),
    .EW_YELLOW_TICKS (8'd2),
    .ALLRED_TICKS    (8'd1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .car_ew     (car_ew),
    .ped_btn    (ped_btn),
    .ns_signal  (ns_signal),
    .ew_signal  (ew_signal),
    .walk       (walk),
    .ew_pending (ew_pending)
  );

  assign lights = {ns_signal, ew_signal, walk};

  always #5 clk = ~clk;

  // Time base: held high, or one strobe every 5th cycle in slow mode.
  always @(negedge clk) begin
    tcnt = (tcnt == 4) ? 0 : tcnt + 1;
    tick = (slow == 0) || (tcnt == 0);
  end

  // Both roads must never show non-red together.
  always @(negedge clk) begin
    if ((ns_signal != 2'b00) && (ew_signal != 2'b00)) overlap++;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the current lights for n consecutive cycles, advancing after each.
  task automatic expect_for(input string tag, input logic [4:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", tag, i), {3'b000, lights}, {3'b000, l});
      step();
    end
  endtask

  // One side-road service starting at the first NS_YELLOW cycle.
  task automatic serve(input string tag);
    expect_for({tag, "_nsy"}, L_NSY, 2);
    expect_for({tag, "_ara"}, L_AR,  1);
    expect_for({tag, "_ewg"}, L_EWG, 3);
    expect_for({tag, "_ewy"}, L_EWY, 2);
    expect_for({tag, "_arb"}, L_AR,  1);
  endtask

  task automatic wait_lights(input string tag, input logic [4:0] l, input int budget);
    int n = 0;
    while (lights !== l && n < budget) begin
      step();
      n++;
    end
    check(tag, {7'd0, lights === l}, 8'd1);
  endtask

  // Count consecutive cycles showing l; ends on the first cycle of the next phase.
  task automatic measure(input string tag, input logic [4:0] l, input int exp);
    int n = 0;
    while (lights === l && n < 255) begin
      step();
      n++;
    end
    check(tag, 8'(n), 8'(exp));
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    step();
    step();
    check("rst_lights", {3'b000, lights}, 8'h00);
    check("rst_pending", {7'd0, ew_pending}, 8'h00);

    // Boot: one ALLRED_B cycle, then NS_GREEN rests without a request.
    rst = 1'b0;
    expect_for("boot_arb", L_AR, 1);
    expect_for("ns_rest", L_NSG, 50);
    check("rest_pending", {7'd0, ew_pending}, 8'h00);

    // One-cycle car pulse during a long green.
    car_ew = 1'b1;
    step();
    car_ew = 1'b0;
    check("car_pending_set", {7'd0, ew_pending}, 8'h01);
    expect_for("car_nsg_last", L_NSG, 1);
    expect_for("car_nsy", L_NSY, 2);
    check("car_pending_ara", {7'd0, ew_pending}, 8'h01);
    expect_for("car_ara", L_AR, 1);
    check("car_pending_clr", {7'd0, ew_pending}, 8'h00);
    expect_for("car_ewg", L_EWG, 3);
    expect_for("car_ewy", L_EWY, 2);
    expect_for("car_arb", L_AR, 1);

    // Button at NS_GREEN cycle 1: green runs cycles 0..4, yellow at cycle 5.
    expect_for("ped_nsg0", L_NSG, 1);
    ped_btn = 1'b1;
    expect_for("ped_nsg1", L_NSG, 1);
    ped_btn = 1'b0;
    check("ped_pending", {7'd0, ew_pending}, 8'h01);
    expect_for("ped_nsg2_4", L_NSG, 3);
    expect_for("ped_nsy", L_NSY, 2);

    // Request at the EW_GREEN entry edge is discarded.
    check("entry_ara", {3'b000, lights}, {3'b000, L_AR});
    car_ew = 1'b1;
    step();
    car_ew = 1'b0;
    check("entry_pending", {7'd0, ew_pending}, 8'h00);
    expect_for("entry_ewg", L_EWG, 3);
    expect_for("entry_ewy", L_EWY, 2);
    expect_for("entry_arb", L_AR, 1);
    expect_for("entry_rest", L_NSG, 20);
    check("entry_rest_pend", {7'd0, ew_pending}, 8'h00);

    // Car held high: continuous 14-cycle service loop.
    car_ew = 1'b1;
    expect_for("hold_nsg_a", L_NSG, 1);
    expect_for("hold_nsg_b", L_NSG, 1);
    serve("hold1");
    expect_for("hold1_nsg", L_NSG, 5);
    serve("hold2");
    expect_for("hold2_nsg", L_NSG, 5);
    car_ew = 1'b0;
    serve("hold3");
    expect_for("hold3_rest", L_NSG, 10);
    check("hold_pend_end", {7'd0, ew_pending}, 8'h00);

    // Tick every 5th cycle: timed phases scale by 5, NS_GREEN = 4*5+1.
    slow   = 1;
    car_ew = 1'b1;
    wait_lights("slow_find_ewg", L_EWG, 200);
    measure("slow_ewg_len", L_EWG, 15);
    measure("slow_ewy_len", L_EWY, 10);
    measure("slow_arb_len", L_AR, 5);
    measure("slow_nsg_len", L_NSG, 21);

    // Reset in mid EW_GREEN beats a same-edge request.
    slow   = 0;
    car_ew = 1'b0;
    wait_lights("mid_find_ewg", L_EWG, 100);
    step();
    check("mid_ewg", {3'b000, lights}, {3'b000, L_EWG});
    car_ew = 1'b1;
    rst    = 1'b1;
    step();
    check("mid_rst_lights", {3'b000, lights}, 8'h00);
    check("mid_rst_pending", {7'd0, ew_pending}, 8'h00);
    rst    = 1'b0;
    car_ew = 1'b0;
    expect_for("post_rst_arb", L_AR, 1);
    expect_for("post_rst_nsg", L_NSG, 3);

    check("no_overlap", 8'(overlap), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
